// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input: two-flop synchroniser, stability-qualified
// level FSM, registered edge pulses and a saturating count of aborted transitions.
module input_debouncer #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic [7:0] bounce_count
);

  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("input_debouncer: STABLE_CYCLES must be >= 1");
  end
  if ((longint'(1) << CNT_WIDTH) < longint'(STABLE_CYCLES)) begin : g_bad_cnt_width
    $error("input_debouncer: CNT_WIDTH too narrow for STABLE_CYCLES");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam bit                   SINGLE   = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_e;

  logic                 s1_q, s1_d;
  logic                 s2_q, s2_d;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dout_q, dout_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [7:0]           bounce_q, bounce_d;
  logic                 bounce_hit;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    s1_d       = din;
    s2_d       = s1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    bounce_hit = 1'b0;

    unique case (state_q)
      IDLE_LO: begin
        cnt_d  = '0;
        dout_d = 1'b0;
        if (s2_q) begin
          if (SINGLE) begin
            state_d = IDLE_HI;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end

      // A revert wins over the terminal count, even on the final qualifying cycle.
      WAIT_HI: begin
        if (!s2_q) begin
          state_d    = IDLE_LO;
          cnt_d      = '0;
          bounce_hit = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      IDLE_HI: begin
        cnt_d  = '0;
        dout_d = 1'b1;
        if (!s2_q) begin
          if (SINGLE) begin
            state_d = IDLE_LO;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end

      WAIT_LO: begin
        if (s2_q) begin
          state_d    = IDLE_HI;
          cnt_d      = '0;
          bounce_hit = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase

    bounce_d = bounce_q;
    if (bounce_hit && (bounce_q != 8'hFF)) begin
      bounce_d = bounce_q + 8'd1;
    end
  end

  // NOTE: every flop here is control state, so all of them take the async reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= IDLE_LO;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      bounce_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      bounce_q <= bounce_d;
    end
  end

  assign dout         = dout_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign bounce_count = bounce_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a STABLE_CYCLES=4 instance and a STABLE_CYCLES=1
// instance, driven from a vector table plus hand sequences through a scoreboard queue.
module tb_input_debouncer;

  typedef struct packed {
    logic       dout;
    logic       rise;
    logic       fall;
    logic [7:0] bc;
  } out_t;

  typedef struct {
    logic din;
    out_t exp;
  } vec_t;

  typedef struct {
    bit    sel;
    out_t  exp;
    string name;
  } sb_t;

  localparam out_t ZERO = '{dout: 1'b0, rise: 1'b0, fall: 1'b0, bc: 8'd0};

  logic       clk;
  logic       rst_n;
  logic       din4, din1;
  logic       dout4, rise4, fall4;
  logic       dout1, rise1, fall1;
  logic [7:0] bc4, bc1;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  input_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(16)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din4),
    .dout         (dout4),
    .rise         (rise4),
    .fall         (fall4),
    .bounce_count (bc4)
  );

  input_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(4)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din1),
    .dout         (dout1),
    .rise         (rise1),
    .fall         (fall1),
    .bounce_count (bc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got no end of test, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  function automatic out_t obs(input bit sel);
    out_t o;
    if (sel) o = '{dout: dout1, rise: rise1, fall: fall1, bc: bc1};
    else     o = '{dout: dout4, rise: rise4, fall: fall4, bc: bc4};
    return o;
  endfunction

  function automatic out_t mk(input logic d, input logic r, input logic f, input int bc);
    out_t o;
    o = '{dout: d, rise: r, fall: f, bc: 8'(bc)};
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got dout=%b rise=%b fall=%b bc=%0d, expected dout=%b rise=%b fall=%b bc=%0d",
               name, act.dout, act.rise, act.fall, act.bc, exp.dout, exp.rise, exp.fall, exp.bc);
    end
  endtask

  // Drive one input value at the falling edge, queue the expectation, let one
  // rising edge pass, then pop and compare at the next falling edge.
  task automatic cycle(input bit sel, input logic d, input out_t exp, input string name);
    sb_t e;
    if (sel) din1 = d;
    else     din4 = d;
    sb.push_back('{sel: sel, exp: exp, name: name});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check(e.name, obs(e.sel), e.exp);
  endtask

  task automatic add(input logic d, input logic r, input logic f, input logic o, input int bc);
    vecs.push_back('{din: d, exp: mk(o, r, f, bc)});
  endtask

  initial begin
    rst_n = 1'b1;
    din4  = 1'b0;
    din1  = 1'b0;
    #1 rst_n = 1'b0;

    // Clean rise: dout/rise after the 6th edge, rise gone after the 7th.
    for (int i = 0; i < 7; i++) add(1'b1, (i == 5), 1'b0, (i >= 5), 0);
    // Clean fall mirrors it.
    for (int i = 0; i < 7; i++) add(1'b0, 1'b0, (i == 5), (i < 5), 0);
    // Bounce: high 2 cycles, revert while counting.
    add(1, 0, 0, 0, 0); add(1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 1);
    // Bounce: high 3 cycles, so the revert lands on the terminal-count edge.
    add(1, 0, 0, 0, 1); add(1, 0, 0, 0, 1); add(1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 2); add(0, 0, 0, 0, 2);

    // Reset held with din toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din4 = ~din4;
      din1 = ~din1;
      @(posedge clk);
      #1;
      check("reset_hold_s4", obs(1'b0), ZERO);
      check("reset_hold_s1", obs(1'b1), ZERO);
    end
    @(negedge clk);
    din4  = 1'b0;
    din1  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, ZERO, "idle_after_reset");

    foreach (vecs[i]) cycle(1'b0, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

    // Async reset while WAIT_HI with cnt = 2.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, mk(0, 0, 0, 2), "pre_reset_wait");
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_s4", obs(1'b0), ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++)
      cycle(1'b0, 1'b1, mk((i >= 5), (i == 5), 0, 0), "rise_after_release");
    for (int i = 0; i < 7; i++)
      cycle(1'b0, 1'b0, mk((i < 5), 0, (i == 5), 0), "fall_after_release");

    // Saturation: 260 two-cycle bounces.
    for (int k = 1; k <= 260; k++) begin
      int prev, now;
      prev = (k - 1 > 255) ? 255 : k - 1;
      now  = (k > 255) ? 255 : k;
      cycle(1'b0, 1'b1, mk(0, 0, 0, prev), "sat_hi");
      cycle(1'b0, 1'b1, mk(0, 0, 0, prev), "sat_hi");
      cycle(1'b0, 1'b0, mk(0, 0, 0, prev), "sat_lo");
      cycle(1'b0, 1'b0, mk(0, 0, 0, prev), "sat_lo");
      cycle(1'b0, 1'b0, mk(0, 0, 0, now),  "sat_count");
      cycle(1'b0, 1'b0, mk(0, 0, 0, now),  "sat_idle");
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, mk(0, 0, 0, 255), "sat_hold");

    // STABLE_CYCLES = 1: single-cycle pulse gives one-cycle dout and back-to-back edges.
    cycle(1'b1, 1'b1, ZERO,             "s1_pulse_e1");
    cycle(1'b1, 1'b0, ZERO,             "s1_pulse_e2");
    cycle(1'b1, 1'b0, mk(1, 1, 0, 0),   "s1_rise");
    cycle(1'b1, 1'b0, mk(0, 0, 1, 0),   "s1_fall");
    cycle(1'b1, 1'b0, ZERO,             "s1_quiet");
    cycle(1'b1, 1'b0, ZERO,             "s1_quiet");

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
